// File: rtl/anita3_evbuf_pkg.sv
// anita3_evbuf_pkg: shared widths, defaults and write-FSM encoding for the TURF event buffer
package anita3_evbuf_pkg;
    localparam int BUF_IDX_W  = 2;
    localparam int WORD_IDX_W = 6;
    localparam int DEF_NBUF   = 4;
    localparam int DEF_NWORDS = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_t;

    function automatic logic [BUF_IDX_W-1:0] buf_next(input logic [BUF_IDX_W-1:0] b, input int nbuf);
        return (int'(b) == nbuf - 1) ? '0 : b + BUF_IDX_W'(1);
    endfunction
endpackage

// File: rtl/anita3_ring_occupancy.sv
// anita3_ring_occupancy: free pointer, occupancy count, full flag and sticky free error for the buffer ring
module anita3_ring_occupancy
    import anita3_evbuf_pkg::*;
#(
    parameter int NBUF = DEF_NBUF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 dec,
    output logic [BUF_IDX_W-1:0] free_buf,
    output logic [2:0]           occupancy,
    output logic                 full,
    output logic                 free_err
);
    logic       dec_ok;
    logic [2:0] occ_next;

    assign dec_ok   = dec && occupancy != 3'd0;
    assign occ_next = occupancy + 3'(inc) - 3'(dec_ok);

    // a free with nothing occupied is ignored but latched as an error until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            free_buf  <= '0;
            occupancy <= '0;
            full      <= 1'b0;
            free_err  <= 1'b0;
        end else begin
            if (dec_ok) free_buf <= buf_next(free_buf, NBUF);
            if (dec && !dec_ok) free_err <= 1'b1;
            occupancy <= occ_next;
            full      <= occ_next == 3'(NBUF);
        end
    end
endmodule

// File: rtl/anita3_event_write_sequencer.sv
// anita3_event_write_sequencer: allocates event buffers round-robin and streams NWORDS source words into them
module anita3_event_write_sequencer
    import anita3_evbuf_pkg::*;
#(
    parameter int NBUF   = DEF_NBUF,
    parameter int NWORDS = DEF_NWORDS,
    parameter int DROP_W = 16
) (
    input  logic              clk33_i,
    input  logic              rst_i,
    input  logic              trig_i,
    input  logic [15:0]       src_dat_i,
    input  logic              src_valid_i,
    output logic              src_ready_o,
    output logic [7:0]        event_wr_addr_o,
    output logic [15:0]       event_wr_dat_o,
    output logic              event_wr_o,
    output logic              event_done_o,
    input  logic              buf_freed_i,
    output logic              busy_o,
    output logic              full_o,
    output logic [2:0]        occupancy_o,
    output logic [DROP_W-1:0] dropped_o,
    output logic              free_err_o
);
    localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(NWORDS - 1);

    wr_state_t              state, state_next;
    logic [BUF_IDX_W-1:0]   wr_buf, free_buf;
    logic [WORD_IDX_W-1:0]  idx;
    logic                   accept, drop, xfer, last_xfer;

    assign accept          = state == IDLE && trig_i && !full_o;
    assign drop            = trig_i && !accept;
    assign xfer            = src_valid_i && src_ready_o;
    assign last_xfer       = xfer && idx == LAST_IDX;
    assign event_wr_o      = xfer;
    assign event_wr_dat_o  = src_dat_i;
    assign event_wr_addr_o = {wr_buf, idx};

    // state register
    always_ff @(posedge clk33_i) begin
        if (rst_i) state <= IDLE;
        else state <= state_next;
    end

    // next state: IDLE -> WRITE on accepted trigger, WRITE -> DONE on last word, DONE lasts one cycle
    always_comb begin
        state_next = (state == IDLE)  ? (accept ? WRITE : IDLE) :
                     (state == WRITE) ? (last_xfer ? DONE : WRITE) : IDLE;
    end

    // state-decoded outputs
    always_comb begin
        src_ready_o  = state == WRITE;
        event_done_o = state == DONE;
        busy_o       = state != IDLE;
    end

    // word index holds at the last word so DONE presents the final address; buffer advances on DONE exit
    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            idx       <= '0;
            wr_buf    <= '0;
            dropped_o <= '0;
        end else begin
            if (accept) idx <= '0;
            else if (xfer && !last_xfer) idx <= idx + WORD_IDX_W'(1);
            if (state == DONE) wr_buf <= buf_next(wr_buf, NBUF);
            if (drop && !(&dropped_o)) dropped_o <= dropped_o + DROP_W'(1);
        end
    end

    anita3_ring_occupancy #(.NBUF(NBUF)) u_ring (
        .clk       (clk33_i),
        .rst       (rst_i),
        .inc       (state == DONE),
        .dec       (buf_freed_i),
        .free_buf  (free_buf),
        .occupancy (occupancy_o),
        .full      (full_o),
        .free_err  (free_err_o)
    );

    // the write pointer always sits occupancy slots ahead of the free pointer
    assert property (@(posedge clk33_i) disable iff (rst_i)
        int'(wr_buf) == (int'(free_buf) + int'(occupancy_o)) % NBUF);
endmodule

// File: tb/tb_anita3_event_write_sequencer.sv
// tb_anita3_event_write_sequencer: randomized scoreboard bench for the event write sequencer
module tb_anita3_event_write_sequencer;
    localparam int NBUF     = 4;
    localparam int NWORDS   = 64;
    localparam int DROP_W   = 4;
    localparam int DROP_MAX = (1 << DROP_W) - 1;
    localparam logic [5:0] LAST = 6'(NWORDS - 1);

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    logic              clk = 0, rst = 1, trig = 0, src_valid = 0, buf_freed = 0;
    logic [15:0]       src_dat = 0;
    logic              src_ready, event_wr, event_done, busy, full, free_err;
    logic [7:0]        wr_addr;
    logic [15:0]       wr_dat;
    logic [2:0]        occupancy;
    logic [DROP_W-1:0] dropped;

    always #5 clk = ~clk;

    anita3_event_write_sequencer #(.NBUF(NBUF), .NWORDS(NWORDS), .DROP_W(DROP_W)) dut (
        .clk33_i         (clk),
        .rst_i           (rst),
        .trig_i          (trig),
        .src_dat_i       (src_dat),
        .src_valid_i     (src_valid),
        .src_ready_o     (src_ready),
        .event_wr_addr_o (wr_addr),
        .event_wr_dat_o  (wr_dat),
        .event_wr_o      (event_wr),
        .event_done_o    (event_done),
        .buf_freed_i     (buf_freed),
        .busy_o          (busy),
        .full_o          (full),
        .occupancy_o     (occupancy),
        .dropped_o       (dropped),
        .free_err_o      (free_err)
    );

    int          n_tests = 0, n_fail = 0;
    wr_t         exp_wr[$];
    logic [7:0]  exp_done[$];
    logic [15:0] src_q[$];
    int          valid_pct = 100;
    bit          hold = 0, pend = 0;
    int          done_cnt = 0, wr_cnt = 0;
    time         done_time = 0;
    bit          prev_last = 0, after_done = 0;
    int          m_occ = 0, m_wr = 0, m_drop = 0;
    bit          m_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v < DROP_MAX) ? v + 1 : v;
    endfunction

    // source: presents queued words with random valid; a word leaves the queue once transferred
    always @(negedge clk) pend <= src_valid && src_ready && !rst;
    always begin
        @(posedge clk); #1;
        if (pend && src_q.size() > 0) void'(src_q.pop_front());
        if (src_q.size() > 0 && !hold && $urandom_range(0, 99) < valid_pct) begin
            src_valid = 1;
            src_dat   = src_q[0];
        end else begin
            src_valid = 0;
            src_dat   = 16'($urandom);
        end
    end

    // monitor: pops the scoreboard on every write strobe and done pulse
    always @(negedge clk) begin
        if (rst) begin
            prev_last  <= 0;
            after_done <= 0;
        end else begin
            if (after_done) begin
                chk("busy_after_done", busy, 0);
                chk("done_one_cycle", event_done, 0);
            end
            if (event_wr) begin
                wr_cnt <= wr_cnt + 1;
                if (exp_wr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h, none expected", wr_addr);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", wr_addr, e.a);
                    chk("wr_dat", wr_dat, e.d);
                end
            end
            if (event_done) begin
                chk("done_after_last_write", prev_last, 1);
                if (exp_done.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: addr 0x%0h, none expected", wr_addr);
                end else chk("done_addr", wr_addr, exp_done.pop_front());
                done_cnt  <= done_cnt + 1;
                done_time <= $time;
            end
            after_done <= event_done;
            prev_last  <= event_wr && wr_addr[5:0] == LAST;
        end
    end

    task automatic check_state(input string tag);
        chk({tag, "_occupancy"}, occupancy, m_occ);
        chk({tag, "_full"}, full, m_occ == NBUF);
        chk({tag, "_dropped"}, dropped, m_drop);
        chk({tag, "_free_err"}, free_err, m_err);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic free_pulse();
        @(posedge clk); #1;
        buf_freed = 1;
        @(posedge clk); #1;
        buf_freed = 0;
        if (m_occ > 0) m_occ--;
        else m_err = 1;
        @(negedge clk);
        check_state("free");
    endtask

    task automatic run_event(input int vpct, input int n_wr_trig, input bit done_trig, input bit done_free, input int abort_at);
        bit          acc;
        int          d0, w0, t;
        time         t0;
        logic [15:0] d;
        @(posedge clk); #1;
        acc = m_occ < NBUF;
        if (acc) begin
            for (int i = 0; i < NWORDS; i++) begin
                d = 16'($urandom);
                exp_wr.push_back('{a: {2'(m_wr), 6'(i)}, d: d});
                src_q.push_back(d);
            end
            exp_done.push_back({2'(m_wr), LAST});
        end else m_drop = sat(m_drop);
        valid_pct = vpct;
        d0 = done_cnt;
        w0 = wr_cnt;
        trig = 1;
        @(posedge clk); #1;
        trig = 0;
        @(negedge clk);
        t0 = $time;
        chk("busy_on_trig", busy, acc);
        chk("ready_on_trig", src_ready, acc);
        if (acc && abort_at > 0) begin
            t = 0;
            while (wr_cnt - w0 < abort_at && t < 5000) begin
                @(negedge clk);
                t++;
            end
            chk("abort_reached", t < 5000, 1);
            hold = 1;
            @(posedge clk); #2;
            rst = 1;
            @(posedge clk); #2;
            rst = 0;
            exp_wr.delete();
            exp_done.delete();
            src_q.delete();
            m_occ = 0; m_wr = 0; m_drop = 0; m_err = 0;
            hold = 0;
            @(negedge clk);
            chk("abort_busy", busy, 0);
            chk("abort_addr", wr_addr, 0);
            chk("abort_no_done", event_done, 0);
            check_state("abort");
            return;
        end
        if (acc) begin
            for (int k = 0; k < n_wr_trig; k++) begin
                @(posedge clk); #1;
                trig = 1;
                @(posedge clk); #1;
                trig = 0;
                m_drop = sat(m_drop);
            end
            if (done_trig || done_free) begin
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!(event_wr && wr_addr[5:0] == LAST) && t < 5000);
                chk("last_write_seen", t < 5000, 1);
                @(posedge clk); #1;
                trig = done_trig;
                buf_freed = done_free;
                @(posedge clk); #1;
                trig = 0;
                buf_freed = 0;
                if (done_trig) m_drop = sat(m_drop);
            end
            for (t = 0; t < 5000 && done_cnt == d0; t++) @(negedge clk);
            chk("done_count", done_cnt - d0, 1);
            if (vpct == 100 && n_wr_trig == 0 && !done_trig && !done_free)
                chk("done_latency", 32'((done_time - t0) / 10), 64);
            if (!done_free) m_occ++;
            else if (m_occ == 0) begin
                m_err = 1;
                m_occ++;
            end
            m_wr = (m_wr + 1) % NBUF;
        end
        repeat (2) @(negedge clk);
        check_state("evt");
    endtask

    initial begin
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", src_ready, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_done", event_done, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_full", full, 0);
        chk("rst_dropped", dropped, 0);
        chk("rst_free_err", free_err, 0);
        @(posedge clk); #1;
        rst = 0;

        run_event(100, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) run_event($urandom_range(40, 100), 0, 0, 0, 0);
        run_event(100, 0, 0, 0, 0);
        free_pulse();
        run_event(70, 0, 0, 0, 0);
        free_pulse();
        free_pulse();
        run_event(80, 3, 1, 0, 0);
        free_pulse();
        run_event(90, 0, 0, 1, 0);
        free_pulse();
        free_pulse();
        free_pulse();

        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) < 3)
                run_event($urandom_range(25, 100), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            else free_pulse();
        end

        if (m_occ == NBUF) free_pulse();
        run_event(100, 0, 0, 0, 20);
        run_event(100, 0, 0, 0, 0);

        while (m_occ < NBUF) run_event(100, 0, 0, 0, 0);
        for (int i = 0; i < DROP_MAX + 3; i++) run_event(100, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
